// File: rtl/sd_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sd_spi_pkg
// Description : Shared constants and state encoding for the SD SPI-mode path.
// Revision    : 1.0 - initial release
// ============================================================================
package sd_spi_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_HUNT      = 3'd0;
    localparam state_t ST_ARG       = 3'd1;
    localparam state_t ST_CRC       = 3'd2;
    localparam state_t ST_FILL      = 3'd3;
    localparam state_t ST_RESP_WAIT = 3'd4;
    localparam state_t ST_RESP_SEND = 3'd5;

    localparam logic [6:0] CRC7_POLY  = 7'h09;
    localparam logic [1:0] START_MASK = 2'b01;
    localparam logic [7:0] FILLER     = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/crc7_serial.sv
`default_nettype none
// ============================================================================
// Module      : crc7_serial
// Description : Bit-serial CRC7 (x^7 + x^3 + 1), zero init, MSB-first input.
// Revision    : 1.0 - initial release
// ============================================================================
module crc7_serial
    import sd_spi_pkg::*;
(
    input  logic       fclk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en,
    input  logic       data_bit,
    output logic [6:0] crc
);

    logic [6:0] r_crc;
    logic       w_fb;

    assign w_fb = r_crc[6] ^ data_bit;

    always_ff @(posedge fclk) begin
        if (rst || clr) begin
            r_crc <= 7'h00;
        end else if (en) begin
            r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC7_POLY : 7'h00);
        end
    end

    assign crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/sd_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : sd_spi_responder
// Description : SD-card-side SPI responder: frames 6-byte commands, checks
//               CRC7, hands the command to a client and returns an R1 byte.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int NCR         = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic        fclk,
    input  logic        rst,
    input  logic        sdcs_n,
    input  logic        sdclk,
    input  logic        sddo,
    output logic        sddi,
    output logic        cmd_valid,
    output logic [5:0]  cmd_index,
    output logic [31:0] cmd_arg,
    output logic        cmd_crc_ok,
    input  logic        resp_valid,
    input  logic [7:0]  resp_data,
    output logic        resp_ready,
    output logic        busy
);

    // Per stage: {sdclk, sdcs_n, sddo}
    logic [2:0]  r_sync [SYNC_STAGES];
    logic        w_sclk;
    logic        w_cs_n;
    logic        w_mosi;
    logic        r_sclk_d;
    logic        w_rise;
    logic        w_fall;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_rx;
    logic [7:0]  w_byte;
    logic        w_byte_done;
    logic        w_start;
    logic [7:0]  r_tx;
    logic [7:0]  w_load_byte;
    logic [1:0]  r_arg_cnt;
    logic [3:0]  r_fill_cnt;
    logic [7:0]  r_resp_byte;
    logic        r_resp_loaded;
    logic        r_hunt_busy;
    logic [5:0]  r_idx_sh;
    logic [31:0] r_arg_sh;

    logic        r_cmd_valid;
    logic [5:0]  r_cmd_index;
    logic [31:0] r_cmd_arg;
    logic        r_cmd_crc_ok;
    logic        w_resp_ready;
    logic        w_busy;

    logic        w_crc_clr;
    logic        w_crc_en;
    logic [6:0]  w_crc;

    always_ff @(posedge fclk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= 3'b011;
            end
        end else begin
            r_sync[0] <= {sdclk, sdcs_n, sddo};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
        end
    end

    assign w_sclk      = r_sync[SYNC_STAGES-1][2];
    assign w_cs_n      = r_sync[SYNC_STAGES-1][1];
    assign w_mosi      = r_sync[SYNC_STAGES-1][0];
    assign w_rise      = w_sclk & ~r_sclk_d & ~w_cs_n;
    assign w_fall      = ~w_sclk & r_sclk_d & ~w_cs_n;
    assign w_byte      = {r_rx, w_mosi};
    assign w_byte_done = w_rise && (r_bit_cnt == 3'd7);
    assign w_start     = (w_byte[7:6] == START_MASK);
    assign w_load_byte = (r_state == ST_RESP_SEND) ? r_resp_byte : FILLER;

    // CRC runs over every HUNT/ARG bit; a rejected HUNT byte wipes it so the
    // next candidate start byte begins from zero.
    assign w_crc_en  = w_rise && ((r_state == ST_HUNT) || (r_state == ST_ARG));
    assign w_crc_clr = w_cs_n
                    || (r_state == ST_FILL) || (r_state == ST_RESP_WAIT)
                    || (r_state == ST_RESP_SEND)
                    || (w_byte_done && (r_state == ST_HUNT) && !w_start);

    crc7_serial u_crc7 (
        .fclk     (fclk),
        .rst      (rst),
        .clr      (w_crc_clr),
        .en       (w_crc_en),
        .data_bit (w_mosi),
        .crc      (w_crc)
    );

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_n) begin
            w_state_nxt = ST_HUNT;
        end else begin
            case (r_state)
                ST_HUNT:      if (w_byte_done && w_start) w_state_nxt = ST_ARG;
                ST_ARG:       if (w_byte_done && (r_arg_cnt == 2'd3)) w_state_nxt = ST_CRC;
                ST_CRC:       if (w_byte_done) w_state_nxt = ST_FILL;
                ST_FILL:      if (w_byte_done && (r_fill_cnt == 4'd1)) w_state_nxt = ST_RESP_WAIT;
                ST_RESP_WAIT: if (resp_valid) w_state_nxt = ST_RESP_SEND;
                ST_RESP_SEND: if (w_byte_done && r_resp_loaded) w_state_nxt = ST_HUNT;
                default:      w_state_nxt = ST_HUNT;
            endcase
        end
    end

    always_comb begin
        w_resp_ready = 1'b0;
        w_busy       = r_hunt_busy;
        if (r_state == ST_RESP_WAIT) begin
            w_resp_ready = 1'b1;
        end
        if (r_state != ST_HUNT) begin
            w_busy = 1'b1;
        end
    end

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_sclk_d      <= 1'b0;
            r_bit_cnt     <= 3'd0;
            r_rx          <= 7'h00;
            r_tx          <= FILLER;
            r_arg_cnt     <= 2'd0;
            r_fill_cnt    <= 4'd0;
            r_resp_byte   <= FILLER;
            r_resp_loaded <= 1'b0;
            r_hunt_busy   <= 1'b0;
            r_idx_sh      <= 6'd0;
            r_arg_sh      <= 32'd0;
            r_cmd_valid   <= 1'b0;
            r_cmd_index   <= 6'd0;
            r_cmd_arg     <= 32'd0;
            r_cmd_crc_ok  <= 1'b0;
        end else begin
            r_sclk_d    <= w_sclk;
            r_cmd_valid <= 1'b0;
            if (w_cs_n) begin
                r_bit_cnt     <= 3'd0;
                r_tx          <= FILLER;
                r_resp_loaded <= 1'b0;
                r_hunt_busy   <= 1'b0;
            end else begin
                if (w_rise) begin
                    r_rx      <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    // A 0 first bit in HUNT could be a start byte
                    if ((r_state == ST_HUNT) && (r_bit_cnt == 3'd0) && !w_mosi) begin
                        r_hunt_busy <= 1'b1;
                    end
                end
                if (w_fall) begin
                    if (r_bit_cnt == 3'd0) begin
                        r_tx <= w_load_byte;
                        if (r_state == ST_RESP_SEND) begin
                            r_resp_loaded <= 1'b1;
                        end
                    end else begin
                        r_tx <= {r_tx[6:0], 1'b1};
                    end
                end
                if (w_byte_done) begin
                    case (r_state)
                        ST_HUNT: begin
                            r_hunt_busy <= 1'b0;
                            if (w_start) begin
                                r_idx_sh  <= w_byte[5:0];
                                r_arg_cnt <= 2'd0;
                            end
                        end
                        ST_ARG: begin
                            r_arg_sh  <= {r_arg_sh[23:0], w_byte};
                            r_arg_cnt <= r_arg_cnt + 2'd1;
                        end
                        ST_CRC: begin
                            r_cmd_valid  <= 1'b1;
                            r_cmd_index  <= r_idx_sh;
                            r_cmd_arg    <= r_arg_sh;
                            r_cmd_crc_ok <= (w_byte[7:1] == w_crc) && w_byte[0];
                            r_fill_cnt   <= 4'(NCR);
                        end
                        ST_FILL: begin
                            r_fill_cnt <= r_fill_cnt - 4'd1;
                        end
                        ST_RESP_SEND: begin
                            if (r_resp_loaded) begin
                                r_resp_loaded <= 1'b0;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                if ((r_state == ST_RESP_WAIT) && resp_valid) begin
                    r_resp_byte <= resp_data;
                end
            end
        end
    end

    assign sddi       = r_tx[7];
    assign cmd_valid  = r_cmd_valid;
    assign cmd_index  = r_cmd_index;
    assign cmd_arg    = r_cmd_arg;
    assign cmd_crc_ok = r_cmd_crc_ok;
    assign resp_ready = w_resp_ready;
    assign busy       = w_busy;

endmodule
`default_nettype wire
